// File: rtl/sensor_emu_pkg.sv
// Shared types and constants for the camera sensor emulator.
// State encoding, pattern selects, counter widths, count clamp helper.
package sensor_emu_pkg;

  localparam int ROW_W = 10;
  localparam int COL_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VBLANK,
    ST_FV_SETUP,
    ST_LINE,
    ST_HBLANK,
    ST_FV_HOLD
  } state_t;

  localparam logic [1:0] PAT_DIAG  = 2'd0;
  localparam logic [1:0] PAT_COL   = 2'd1;
  localparam logic [1:0] PAT_FRAME = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  function automatic logic [15:0] clamp_cnt(
    input logic [15:0] v,
    input logic [15:0] max
  );
    if (v == 16'd0) return 16'd1;
    if (v > max) return max;
    return v;
  endfunction

endpackage

// File: rtl/sensor_emu_pattern.sv
// Registered pixel pattern generator for the sensor emulator.
// SENSOR_EMU_PATTERN_EN enables the selectable pattern mux.
module sensor_emu_pattern
  import sensor_emu_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       valid,
  input  logic [7:0] row,
  input  logic [7:0] col,
`ifdef SENSOR_EMU_PATTERN_EN
  input  logic [7:0] frame,
  input  logic [1:0] sel,
`endif
  output logic [7:0] din
);

  logic [7:0] pix;

  // Pixel value for the upcoming cycle's row/col
  always_comb begin
    pix = row + col;
`ifdef SENSOR_EMU_PATTERN_EN
    unique case (sel)
      PAT_DIAG:  pix = row + col;
      PAT_COL:   pix = col;
      PAT_FRAME: pix = frame;
      PAT_CHECK: pix = {8{row[3] ^ col[3]}};
      default:   pix = row + col;
    endcase
`endif
  end

  // Data register, forced to 0 outside active pixels
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) din <= '0;
    else          din <= valid ? pix : 8'd0;
  end

endmodule

// File: rtl/sensor_emulator.sv
// Parallel camera interface transmitter: fv/lv/pixel generator.
// SENSOR_EMU_PATTERN_EN enables pattern_sel; otherwise row+col only.
module sensor_emulator
  import sensor_emu_pkg::*;
#(
  parameter int MAX_ROWS = 1023,
  parameter int MAX_COLS = 2047
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [9:0]  cfg_rows,
  input  logic [10:0] cfg_cols,
  input  logic [7:0]  cfg_fv_setup,
  input  logic [7:0]  cfg_hblank,
  input  logic [15:0] cfg_vblank,
  input  logic [1:0]  pattern_sel,
  output logic        sensor_state,
  output logic        sensor_fv,
  output logic        sensor_lv,
  output logic [7:0]  sensor_din,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  state_t state, state_n;

  logic [15:0]      cnt, cnt_n;
  logic [ROW_W-1:0] row, row_n, rows_l;
  logic [COL_W-1:0] col, col_n, cols_l;
  logic [7:0]       setup_l, hblank_l;
  logic [15:0]      vblank_l;
  logic             latch;
  logic             done_n;
  logic             lv_n;
  logic             fv_n;

`ifdef SENSOR_EMU_PATTERN_EN
  logic [1:0] pat_l;
`else
  logic unused_sel;
  assign unused_sel = ^pattern_sel;
`endif

  // Next state, phase counter and row/col counters
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    row_n   = row;
    col_n   = col;
    latch   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (enable) begin
          latch   = 1'b1;
          state_n = ST_VBLANK;
        end
      end
      ST_VBLANK: begin
        if (cnt == vblank_l - 16'd1) begin
          state_n = ST_FV_SETUP;
          cnt_n   = '0;
        end
      end
      ST_FV_SETUP: begin
        if (cnt == {8'd0, setup_l} - 16'd1) begin
          state_n = ST_LINE;
          cnt_n   = '0;
          row_n   = '0;
          col_n   = '0;
        end
      end
      ST_LINE: begin
        col_n = col + COL_W'(1);
        if (col == cols_l - COL_W'(1)) begin
          col_n = '0;
          cnt_n = '0;
          if (row == rows_l - ROW_W'(1)) begin
            state_n = ST_FV_HOLD;
          end else begin
            state_n = ST_HBLANK;
            row_n   = row + ROW_W'(1);
          end
        end
      end
      ST_HBLANK: begin
        if (cnt == {8'd0, hblank_l} - 16'd1) begin
          state_n = ST_LINE;
          cnt_n   = '0;
        end
      end
      ST_FV_HOLD: begin
        if (cnt == {8'd0, setup_l} - 16'd1) begin
          cnt_n = '0;
          if (enable) begin
            latch   = 1'b1;
            state_n = ST_VBLANK;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
    done_n = (state_n == ST_FV_HOLD) &&
             (cnt_n == {8'd0, setup_l} - 16'd1);
    lv_n   = (state_n == ST_LINE);
    fv_n   = (state_n == ST_FV_SETUP) || (state_n == ST_LINE) ||
             (state_n == ST_HBLANK)   || (state_n == ST_FV_HOLD);
  end

  // FSM and counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      row   <= row_n;
      col   <= col_n;
    end
  end

  // Frame configuration, captured only at frame boundaries
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rows_l   <= ROW_W'(1);
      cols_l   <= COL_W'(1);
      setup_l  <= 8'd1;
      hblank_l <= 8'd1;
      vblank_l <= 16'd1;
`ifdef SENSOR_EMU_PATTERN_EN
      pat_l    <= PAT_DIAG;
`endif
    end else if (latch) begin
      rows_l   <= ROW_W'(clamp_cnt(16'(cfg_rows), 16'(MAX_ROWS)));
      cols_l   <= COL_W'(clamp_cnt(16'(cfg_cols), 16'(MAX_COLS)));
      setup_l  <= 8'(clamp_cnt({8'd0, cfg_fv_setup}, 16'hffff));
      hblank_l <= 8'(clamp_cnt({8'd0, cfg_hblank}, 16'hffff));
      vblank_l <= clamp_cnt(cfg_vblank, 16'hffff);
`ifdef SENSOR_EMU_PATTERN_EN
      pat_l    <= pattern_sel;
`endif
    end
  end

  // Registered interface outputs, aligned with the state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sensor_state <= 1'b0;
      sensor_fv    <= 1'b0;
      sensor_lv    <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      sensor_state <= (state_n != ST_IDLE);
      sensor_fv    <= fv_n;
      sensor_lv    <= lv_n;
      frame_done   <= done_n;
      if (done_n) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  sensor_emu_pattern u_pattern (
    .clock   (clock),
    .reset_n (reset_n),
    .valid   (lv_n),
    .row     (row_n[7:0]),
    .col     (col_n[7:0]),
`ifdef SENSOR_EMU_PATTERN_EN
    .frame   (frame_cnt[7:0]),
    .sel     (pat_l),
`endif
    .din     (sensor_din)
  );

endmodule

// File: tb/tb_sensor_emulator.sv
// Self-checking bench for sensor_emulator.
// Expected waveforms are built per frame from the timing rules.
module tb_sensor_emulator;

  localparam int MR = 6;
  localparam int MC = 20;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  cfg_rows = '0;
  logic [10:0] cfg_cols = '0;
  logic [7:0]  cfg_fv_setup = '0;
  logic [7:0]  cfg_hblank = '0;
  logic [15:0] cfg_vblank = '0;
  logic [1:0]  pattern_sel = '0;
  logic        sensor_state;
  logic        sensor_fv;
  logic        sensor_lv;
  logic [7:0]  sensor_din;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic [11:0] obs;

  int n_vec = 0;
  int n_err = 0;

  sensor_emulator #(.MAX_ROWS(MR), .MAX_COLS(MC)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .cfg_rows     (cfg_rows),
    .cfg_cols     (cfg_cols),
    .cfg_fv_setup (cfg_fv_setup),
    .cfg_hblank   (cfg_hblank),
    .cfg_vblank   (cfg_vblank),
    .pattern_sel  (pattern_sel),
    .sensor_state (sensor_state),
    .sensor_fv    (sensor_fv),
    .sensor_lv    (sensor_lv),
    .sensor_din   (sensor_din),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt)
  );

  always #5 clock = ~clock;

  assign obs = {sensor_state, sensor_fv, sensor_lv,
                sensor_din, frame_done};

  function automatic int eff(input int v, input int mx);
    if (v == 0) return 1;
    if (v > mx) return mx;
    return v;
  endfunction

  function automatic logic [7:0] pix(
    input int p, input int r, input int c, input int f
  );
`ifndef SENSOR_EMU_PATTERN_EN
    p = 0;
`endif
    case (p)
      0: return 8'((r + c) % 256);
      1: return 8'(c % 256);
      2: return 8'(f % 256);
      default:
        return (((r / 8) % 2) != ((c / 8) % 2)) ? 8'hff : 8'h00;
    endcase
  endfunction

  task automatic check(
    input string tag, input logic [11:0] exp,
    input int fc, input bit chk_fc
  );
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    if (chk_fc) begin
      n_vec++;
      assert (frame_cnt === 16'(fc)) else begin
        n_err++;
        $error("FAIL %s frame_cnt: observed %0d expected %0d",
               tag, frame_cnt, fc);
      end
    end
  endtask

  // One frame from first VBLANK cycle to last FV_HOLD cycle.
  // After the check at index act_at, enable/cfg_cols are updated.
  task automatic expect_frame(
    input string tag,
    input int rows, input int cols, input int su,
    input int hb, input int vb, input int pat, input int fc,
    input int act_at, input logic act_en, input logic [10:0] act_cols
  );
    logic [11:0] q[$];
    int re, ce, se, he, ve;
    re = eff(rows, MR);
    ce = eff(cols, MC);
    se = eff(su, 65535);
    he = eff(hb, 65535);
    ve = eff(vb, 65535);
    for (int i = 0; i < ve; i++) q.push_back({3'b100, 8'd0, 1'b0});
    for (int i = 0; i < se; i++) q.push_back({3'b110, 8'd0, 1'b0});
    for (int r = 0; r < re; r++) begin
      for (int c = 0; c < ce; c++)
        q.push_back({3'b111, pix(pat, r, c, fc), 1'b0});
      if (r < re - 1)
        for (int i = 0; i < he; i++)
          q.push_back({3'b110, 8'd0, 1'b0});
    end
    for (int i = 0; i < se; i++)
      q.push_back({3'b110, 8'd0, (i == se - 1)});
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clock);
      #1;
      check(tag, q[i], fc, !q[i][0]);
      if (i == act_at) begin
        enable   = act_en;
        cfg_cols = act_cols;
      end
    end
  endtask

  task automatic expect_idle(input string tag, input int n, input int fc);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      check(tag, 12'h000, fc, 1'b1);
    end
  endtask

  task automatic set_cfg(
    input int rows, input int cols, input int su,
    input int hb, input int vb, input int pat
  );
    cfg_rows     = 10'(rows);
    cfg_cols     = 11'(cols);
    cfg_fv_setup = 8'(su);
    cfg_hblank   = 8'(hb);
    cfg_vblank   = 16'(vb);
    pattern_sel  = 2'(pat);
  endtask

  initial begin
    int r, c, s, h, v, p, fc;

    // reset state
    #2;
    check("reset", 12'h000, 0, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    check("reset_hold", 12'h000, 0, 1'b1);
    reset_n = 1'b1;
    expect_idle("idle_after_reset", 2, 0);

    // reset asserted mid-line
    set_cfg(3, 4, 1, 1, 2, 0);
    enable = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("mid_line", {3'b111, pix(0, 0, 1, 0), 1'b0}, 0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 12'h000, 0, 1'b1);
    @(posedge clock);
    #1;
    set_cfg(3, 4, 1, 1, 2, 2);
    reset_n = 1'b1;

    // pattern 2 over three frames, counting from 0 after reset
    expect_frame("pat2_f0", 3, 4, 1, 1, 2, 2, 0, -1, 1'b1, 11'd4);
    expect_frame("pat2_f1", 3, 4, 1, 1, 2, 2, 1, -1, 1'b1, 11'd4);
    expect_frame("pat2_f2", 3, 4, 1, 1, 2, 2, 2, 0, 1'b0, 11'd4);
    expect_idle("pat2_idle", 2, 3);

    // 4x8 geometry, pattern 1, back-to-back frames
    set_cfg(4, 8, 2, 3, 5, 1);
    enable = 1'b1;
    expect_frame("geo_f0", 4, 8, 2, 3, 5, 1, 3, -1, 1'b1, 11'd8);
    expect_frame("geo_f1", 4, 8, 2, 3, 5, 1, 4, 10, 1'b0, 11'd8);
    expect_idle("geo_idle", 2, 5);

    // all-zero config: 1x1 frame, 4-cycle period
    set_cfg(0, 0, 0, 0, 0, 0);
    enable = 1'b1;
    expect_frame("zero_f0", 0, 0, 0, 0, 0, 0, 5, -1, 1'b1, 11'd0);
    expect_frame("zero_f1", 0, 0, 0, 0, 0, 0, 6, 0, 1'b0, 11'd0);
    expect_idle("zero_idle", 1, 7);

    // enable dropped during row 1 of 4
    set_cfg(4, 8, 2, 3, 5, 0);
    enable = 1'b1;
    expect_frame("drop_f0", 4, 8, 2, 3, 5, 0, 7, 20, 1'b0, 11'd8);
    expect_idle("drop_idle", 2, 8);

    // cfg_cols 8 -> 16 mid-frame, checkerboard
    set_cfg(4, 8, 1, 2, 3, 3);
    enable = 1'b1;
    expect_frame("cols_f0", 4, 8, 1, 2, 3, 3, 8, 15, 1'b1, 11'd16);
    expect_frame("cols_f1", 4, 16, 1, 2, 3, 3, 9, 0, 1'b0, 11'd16);
    expect_idle("cols_idle", 1, 10);

    // randomized geometry, including clamped values
    fc = 10;
    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(0, MR + 3);
      c = $urandom_range(0, MC + 4);
      s = $urandom_range(0, 3);
      h = $urandom_range(0, 4);
      v = $urandom_range(0, 4);
      p = $urandom_range(0, 3);
      set_cfg(r, c, s, h, v, p);
      enable = 1'b1;
      expect_frame("rand_f0", r, c, s, h, v, p, fc, -1, 1'b1, 11'(c));
      expect_frame("rand_f1", r, c, s, h, v, p, fc + 1, 0, 1'b0, 11'(c));
      fc += 2;
      expect_idle("rand_idle", 1, fc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
